resilient_stage_ctrl: RTL and testbench

//  Synchronous, parametrised successor of the bundled-data resilient pipeline stage controller.

---
 rtl/resilient_pkg.sv | 21 ++
 rtl/resilient_stage_ctrl_delay_cnt.sv | 27 ++
 rtl/resilient_stage_ctrl.sv | 128 ++++++++++++
 tb/tb_resilient_stage_ctrl.sv | 271 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/resilient_pkg.sv
// Shared types and sizing helpers for the resilient pipeline stage controller.
package resilient_pkg;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    EVAL   = 3'd1,
    SAMPLE = 3'd2,
    RECOV  = 3'd3,
    RREQ   = 3'd4,
    RWAIT  = 3'd5
  } state_t;

  // Width of the shared delay counter; it only ever holds values up to max-1.
  function automatic int unsigned dly_cnt_w(input int unsigned eval_cyc,
                                            input int unsigned recov_cyc);
    int unsigned m;
    m = (eval_cyc > recov_cyc) ? eval_cyc : recov_cyc;
    return (m > 1) ? $clog2(m) : 1;
  endfunction

endpackage

// File: rtl/resilient_stage_ctrl_delay_cnt.sv
// Loadable down-counter with zero flag, shared by the evaluation and recovery waits.
module stage_delay_cnt #(
  parameter int unsigned W = 1
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         load,
  input  logic [W-1:0] load_val,
  input  logic         dec,
  output logic         zero
);

  logic [W-1:0] cnt;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      cnt <= '0;
    end else if (load) begin
      cnt <= load_val;
    end else if (dec && !zero) begin
      cnt <= cnt - 1'b1;
    end
  end

  assign zero = (cnt == '0);

endmodule

// File: rtl/resilient_stage_ctrl.sv
// Bundled-data resilient stage controller: capture, timed sample, error recovery,
// then forward on the right 4-phase channel.
module resilient_stage_ctrl
  import resilient_pkg::*;
#(
  parameter int unsigned DATA_W    = 8,
  parameter int unsigned ERR_W     = 2,
  parameter int unsigned EVAL_CYC  = 2,
  parameter int unsigned RECOV_CYC = 1,
  parameter int unsigned CNT_W     = 8
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              lreq,
  output logic              lack,
  input  logic [DATA_W-1:0] ldata,
  output logic              rreq,
  input  logic              rack,
  output logic [DATA_W-1:0] rdata,
  output logic              sample,
  input  logic [ERR_W-1:0]  err,
  output logic [CNT_W-1:0]  err_cnt,
  output logic              busy
);

  localparam int unsigned CW = dly_cnt_w(EVAL_CYC, RECOV_CYC);
  localparam logic [CW-1:0] EVAL_LD  = CW'(EVAL_CYC - 1);
  localparam logic [CW-1:0] RECOV_LD = CW'(RECOV_CYC - 1);

  state_t        state, state_nxt;
  logic          capture;
  logic          cnt_load, cnt_dec, cnt_zero;
  logic [CW-1:0] cnt_ld_val;
  logic          err_hit;

  assign capture = (state == IDLE) && lreq && !lack;
  assign busy    = (state != IDLE);

  stage_delay_cnt #(.W(CW)) u_dly (
    .clk      (clk),
    .rst_n    (rst_n),
    .load     (cnt_load),
    .load_val (cnt_ld_val),
    .dec      (cnt_dec),
    .zero     (cnt_zero)
  );

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt  = state;
    cnt_load   = 1'b0;
    cnt_ld_val = EVAL_LD;
    cnt_dec    = 1'b0;
    err_hit    = 1'b0;
    sample     = 1'b0;
    rreq       = 1'b0;
    case (state)
      IDLE: begin
        if (capture) begin
          state_nxt = EVAL;
          cnt_load  = 1'b1;
        end
      end
      EVAL: begin
        if (cnt_zero) state_nxt = SAMPLE;
        else          cnt_dec   = 1'b1;
      end
      SAMPLE: begin
        sample = 1'b1;
        if (|err) begin
          err_hit    = 1'b1;
          state_nxt  = RECOV;
          cnt_load   = 1'b1;
          cnt_ld_val = RECOV_LD;
        end else begin
          state_nxt = RREQ;
        end
      end
      RECOV: begin
        if (cnt_zero) state_nxt = RREQ;
        else          cnt_dec   = 1'b1;
      end
      RREQ: begin
        rreq = 1'b1;
        if (rack) state_nxt = RWAIT;
      end
      RWAIT: begin
        if (!rack) state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  // Left acknowledge runs on its own so an lreq fall never waits on the FSM.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      lack <= 1'b0;
    end else if (capture) begin
      lack <= 1'b1;
    end else if (lack && !lreq) begin
      lack <= 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      rdata <= '0;
    end else if (capture) begin
      rdata <= ldata;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      err_cnt <= '0;
    end else if (err_hit && (err_cnt != '1)) begin
      err_cnt <= err_cnt + 1'b1;
    end
  end

endmodule

// File: tb/tb_resilient_stage_ctrl.sv
// Bench for resilient_stage_ctrl: vector table, corner-case sequences and a random run
// against a token-age reference model. Two instances share stimulus (8-bit and 2-bit counters).
module tb_resilient_stage_ctrl;

  localparam int EV = 2;
  localparam int RC = 1;

  logic       clk = 1'b0;
  logic       rst_n, lreq, rack;
  logic [7:0] ldata;
  logic [1:0] err;

  logic       lack_a, rreq_a, sample_a, busy_a;
  logic [7:0] rdata_a, cnt_a;
  logic       lack_b, rreq_b, sample_b, busy_b;
  logic [7:0] rdata_b;
  logic [1:0] cnt_b;

  always #5 clk = ~clk;

  resilient_stage_ctrl #(.DATA_W(8), .ERR_W(2), .EVAL_CYC(EV), .RECOV_CYC(RC), .CNT_W(8)) dut (
    .clk(clk), .rst_n(rst_n), .lreq(lreq), .lack(lack_a), .ldata(ldata),
    .rreq(rreq_a), .rack(rack), .rdata(rdata_a), .sample(sample_a),
    .err(err), .err_cnt(cnt_a), .busy(busy_a)
  );

  resilient_stage_ctrl #(.DATA_W(8), .ERR_W(2), .EVAL_CYC(EV), .RECOV_CYC(RC), .CNT_W(2)) dut_sat (
    .clk(clk), .rst_n(rst_n), .lreq(lreq), .lack(lack_b), .ldata(ldata),
    .rreq(rreq_b), .rack(rack), .rdata(rdata_b), .sample(sample_b),
    .err(err), .err_cnt(cnt_b), .busy(busy_b)
  );

  int n_vec  = 0;
  int n_miss = 0;
  int cyc    = 0;
  int cap_cyc = 0;

  // Reference model: a token is tracked by its age since capture.
  int m_lack = 0, m_tok = 0, m_age = 0, m_errd = 0, m_rr = 0, m_rw = 0;
  int m_cnt8 = 0, m_cnt2 = 0;
  logic [7:0] m_rdata = 8'h00;

  typedef struct {
    logic       rst_n, lreq;
    logic [7:0] ldata;
    logic       rack;
    logic [1:0] err;
    logic       lack, rreq, sample, busy;
    logic [7:0] rdata;
    logic [7:0] cnt;
  } vec_t;

  vec_t tbl [16];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_miss++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic model_edge();
    bit cap;
    if (!rst_n) begin
      m_lack = 0; m_tok = 0; m_age = 0; m_errd = 0; m_rr = 0; m_rw = 0;
      m_cnt8 = 0; m_cnt2 = 0; m_rdata = 8'h00;
    end else begin
      cap = (m_tok == 0) && lreq && (m_lack == 0);
      if (cap)                          m_lack = 1;
      else if ((m_lack != 0) && !lreq)  m_lack = 0;
      if (cap) begin
        m_tok = 1; m_age = 0; m_errd = 0; m_rr = 0; m_rw = 0; m_rdata = ldata;
      end else if (m_tok != 0) begin
        if (m_rr != 0) begin
          if (rack) begin m_rr = 0; m_rw = 1; end
        end else if (m_rw != 0) begin
          if (!rack) begin m_tok = 0; m_rw = 0; end
        end else begin
          if ((m_age == EV) && (err != 2'b00)) begin
            m_errd = 1;
            m_cnt8 = (m_cnt8 == 255) ? 255 : m_cnt8 + 1;
            m_cnt2 = (m_cnt2 == 3) ? 3 : m_cnt2 + 1;
          end
          m_age++;
          if (m_age == EV + 1 + ((m_errd != 0) ? RC : 0)) m_rr = 1;
        end
      end
    end
  endtask

  task automatic step();
    @(posedge clk);
    model_edge();
    cyc++;
    #1;
  endtask

  task automatic chk_model();
    int ms;
    ms = ((m_tok != 0) && (m_rr == 0) && (m_rw == 0) && (m_age == EV)) ? 1 : 0;
    chk("rnd_lack",     32'(lack_a),   32'(m_lack));
    chk("rnd_lack_b",   32'(lack_b),   32'(m_lack));
    chk("rnd_rreq",     32'(rreq_a),   32'(m_rr));
    chk("rnd_rreq_b",   32'(rreq_b),   32'(m_rr));
    chk("rnd_sample",   32'(sample_a), 32'(ms));
    chk("rnd_sample_b", 32'(sample_b), 32'(ms));
    chk("rnd_busy",     32'(busy_a),   32'(m_tok));
    chk("rnd_busy_b",   32'(busy_b),   32'(m_tok));
    chk("rnd_rdata",    32'(rdata_a),  32'(m_rdata));
    chk("rnd_rdata_b",  32'(rdata_b),  32'(m_rdata));
    chk("rnd_cnt8",     32'(cnt_a),    32'(m_cnt8));
    chk("rnd_cnt2",     32'(cnt_b),    32'(m_cnt2));
  endtask

  task automatic do_capture(input logic [7:0] d);
    int t;
    ldata = d; lreq = 1'b1;
    t = 0;
    while (!lack_a && t < 20) begin step(); t++; end
    chk("cap_lack", 32'(lack_a), 32'd1);
    chk("cap_rdata", 32'(rdata_a), 32'(d));
    cap_cyc = cyc;
    lreq = 1'b0;
  endtask

  task automatic finish_token(input logic [1:0] e);
    int t;
    t = 0;
    while (!sample_a && t < 20) begin step(); t++; end
    chk("tok_sample", 32'(sample_a), 32'd1);
    chk("tok_sample_lat", 32'(cyc - cap_cyc), 32'(EV));
    err = e; step(); err = 2'b00;
    t = 0;
    while (!rreq_a && t < 20) begin step(); t++; end
    chk("tok_rreq", 32'(rreq_a), 32'd1);
    chk("tok_rreq_lat", 32'(cyc - cap_cyc), 32'(EV + 1 + ((e != 2'b00) ? RC : 0)));
    rack = 1'b1;
    t = 0;
    while (rreq_a && t < 20) begin step(); t++; end
    chk("tok_rreq_drop", 32'(rreq_a), 32'd0);
    rack = 1'b0;
    t = 0;
    while (busy_a && t < 20) begin step(); t++; end
    chk("tok_idle", 32'(busy_a), 32'd0);
  endtask

  initial begin
    int sat_exp [5] = '{1, 2, 3, 3, 3};
    int t;

    rst_n = 1'b0; lreq = 1'b0; rack = 1'b0; ldata = 8'h00; err = 2'b00;

    //            rst  lreq ldata  rack err    lack rreq smp busy rdata  cnt
    tbl[0]  = '{1'b0, 1'b1, 8'hA5, 1'b0, 2'd0, 1'b0, 1'b0, 1'b0, 1'b0, 8'h00, 8'd0};
    tbl[1]  = '{1'b0, 1'b1, 8'hA5, 1'b0, 2'd0, 1'b0, 1'b0, 1'b0, 1'b0, 8'h00, 8'd0};
    tbl[2]  = '{1'b1, 1'b1, 8'hA5, 1'b0, 2'd0, 1'b1, 1'b0, 1'b0, 1'b1, 8'hA5, 8'd0};
    tbl[3]  = '{1'b1, 1'b0, 8'hA5, 1'b0, 2'd0, 1'b0, 1'b0, 1'b0, 1'b1, 8'hA5, 8'd0};
    tbl[4]  = '{1'b1, 1'b0, 8'hA5, 1'b0, 2'd0, 1'b0, 1'b0, 1'b1, 1'b1, 8'hA5, 8'd0};
    tbl[5]  = '{1'b1, 1'b0, 8'hA5, 1'b0, 2'd0, 1'b0, 1'b1, 1'b0, 1'b1, 8'hA5, 8'd0};
    tbl[6]  = '{1'b1, 1'b0, 8'hA5, 1'b0, 2'd0, 1'b0, 1'b1, 1'b0, 1'b1, 8'hA5, 8'd0};
    tbl[7]  = '{1'b1, 1'b0, 8'hA5, 1'b1, 2'd0, 1'b0, 1'b0, 1'b0, 1'b1, 8'hA5, 8'd0};
    tbl[8]  = '{1'b1, 1'b0, 8'hA5, 1'b0, 2'd0, 1'b0, 1'b0, 1'b0, 1'b0, 8'hA5, 8'd0};
    tbl[9]  = '{1'b1, 1'b1, 8'h3C, 1'b0, 2'd0, 1'b1, 1'b0, 1'b0, 1'b1, 8'h3C, 8'd0};
    tbl[10] = '{1'b1, 1'b0, 8'h3C, 1'b0, 2'd2, 1'b0, 1'b0, 1'b0, 1'b1, 8'h3C, 8'd0};
    tbl[11] = '{1'b1, 1'b0, 8'h3C, 1'b0, 2'd0, 1'b0, 1'b0, 1'b1, 1'b1, 8'h3C, 8'd0};
    tbl[12] = '{1'b1, 1'b0, 8'h3C, 1'b0, 2'd1, 1'b0, 1'b0, 1'b0, 1'b1, 8'h3C, 8'd1};
    tbl[13] = '{1'b1, 1'b0, 8'h3C, 1'b0, 2'd0, 1'b0, 1'b1, 1'b0, 1'b1, 8'h3C, 8'd1};
    tbl[14] = '{1'b1, 1'b0, 8'h3C, 1'b1, 2'd0, 1'b0, 1'b0, 1'b0, 1'b1, 8'h3C, 8'd1};
    tbl[15] = '{1'b1, 1'b0, 8'h3C, 1'b0, 2'd0, 1'b0, 1'b0, 1'b0, 1'b0, 8'h3C, 8'd1};

    for (int i = 0; i < 16; i++) begin
      rst_n = tbl[i].rst_n; lreq = tbl[i].lreq; ldata = tbl[i].ldata;
      rack  = tbl[i].rack;  err  = tbl[i].err;
      step();
      chk($sformatf("t%0d_lack", i),   32'(lack_a),   32'(tbl[i].lack));
      chk($sformatf("t%0d_rreq", i),   32'(rreq_a),   32'(tbl[i].rreq));
      chk($sformatf("t%0d_sample", i), 32'(sample_a), 32'(tbl[i].sample));
      chk($sformatf("t%0d_busy", i),   32'(busy_a),   32'(tbl[i].busy));
      chk($sformatf("t%0d_rdata", i),  32'(rdata_a),  32'(tbl[i].rdata));
      chk($sformatf("t%0d_cnt", i),    32'(cnt_a),    32'(tbl[i].cnt));
      chk($sformatf("t%0d_cnt_b", i),  32'(cnt_b),    32'(tbl[i].cnt));
    end
    err = 2'b00; rack = 1'b0; lreq = 1'b0;

    // Saturation of the 2-bit counter over five error tokens.
    rst_n = 1'b0; step(); step(); rst_n = 1'b1;
    for (int i = 0; i < 5; i++) begin
      do_capture(8'(i + 16));
      finish_token(2'b01);
      chk("sat_cnt2", 32'(cnt_b), 32'(sat_exp[i]));
      chk("sat_cnt8", 32'(cnt_a), 32'(i + 1));
    end

    // Back-pressure with a second request queued behind the held token.
    do_capture(8'h5A);
    t = 0;
    while (!rreq_a && t < 20) begin step(); t++; end
    chk("bp_rreq_rise", 32'(rreq_a), 32'd1);
    for (int i = 0; i < 20; i++) begin
      if (i == 3) begin lreq = 1'b1; ldata = 8'hC3; end
      step();
      chk("bp_rreq_hold", 32'(rreq_a), 32'd1);
      chk("bp_rdata", 32'(rdata_a), 32'h5A);
      chk("bp_no_cap", 32'(lack_a), 32'd0);
    end
    rack = 1'b1; step();
    chk("bp_rreq_drop", 32'(rreq_a), 32'd0);
    chk("bp_rwait_busy", 32'(busy_a), 32'd1);
    rack = 1'b0; step();
    chk("bp_idle", 32'(busy_a), 32'd0);
    chk("bp_idle_nocap", 32'(lack_a), 32'd0);
    chk("bp_idle_rdata", 32'(rdata_a), 32'h5A);
    step();
    chk("bp_second_cap", 32'(lack_a), 32'd1);
    chk("bp_second_rdata", 32'(rdata_a), 32'hC3);
    cap_cyc = cyc;
    lreq = 1'b0;
    finish_token(2'b00);

    // rack already high when rreq rises: rreq still shows for one cycle.
    rack = 1'b1;
    do_capture(8'h11);
    t = 0;
    while (!rreq_a && t < 20) begin step(); t++; end
    chk("early_rack_rreq", 32'(rreq_a), 32'd1);
    step();
    chk("early_rack_drop", 32'(rreq_a), 32'd0);
    rack = 1'b0; step();
    chk("early_rack_idle", 32'(busy_a), 32'd0);

    // Reset while in recovery.
    do_capture(8'h77);
    t = 0;
    while (!sample_a && t < 20) begin step(); t++; end
    chk("rr_sample", 32'(sample_a), 32'd1);
    err = 2'b11; step(); err = 2'b00;
    chk("rr_recov_busy", 32'(busy_a), 32'd1);
    chk("rr_recov_rreq", 32'(rreq_a), 32'd0);
    chk("rr_recov_cnt8", 32'(cnt_a), 32'd6);
    chk("rr_recov_cnt2", 32'(cnt_b), 32'd3);
    rst_n = 1'b0; step(); rst_n = 1'b1;
    chk("rr_lack", 32'(lack_a), 32'd0);
    chk("rr_rreq", 32'(rreq_a), 32'd0);
    chk("rr_sample0", 32'(sample_a), 32'd0);
    chk("rr_busy", 32'(busy_a), 32'd0);
    chk("rr_rdata", 32'(rdata_a), 32'd0);
    chk("rr_cnt8", 32'(cnt_a), 32'd0);
    chk("rr_cnt2", 32'(cnt_b), 32'd0);
    do_capture(8'h99);
    finish_token(2'b00);
    chk("rr_next_rdata", 32'(rdata_a), 32'h99);
    chk("rr_next_cnt", 32'(cnt_a), 32'd0);

    // Random stimulus against the reference model.
    rst_n = 1'b0; step(); chk_model();
    for (int i = 0; i < 1500; i++) begin
      rst_n = ($urandom_range(0, 63) != 0);
      lreq  = 1'($urandom_range(0, 1));
      rack  = 1'($urandom_range(0, 1));
      err   = 2'($urandom_range(0, 3));
      ldata = 8'($urandom);
      step();
      chk_model();
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule
